// File: rtl/cas_player.sv
// -----------------------------------------------------------------------------
// cas_player
// Cassette playback engine for the TRS-80 core. It reads a CAS image byte by
// byte from the cassette region of the download RAM. It regenerates the
// Level II 500-baud pulse train for the machine's cassette input.
// Each 8-bit byte is sent MSB first as eight bit cells. A bit cell has a
// clock pulse (01 then 10) at its start. A 1 bit adds a second pulse pair
// starting at mid-cell.
//
// Optional feature, selected by the macro CAS_MOTOR_GATE_EN:
//   defined   - playback freezes in place while the cassette motor is off
//   undefined - motor_on is ignored and playback runs free once started
//
// Ports:
//   clk_sys   in   system clock (42 MHz)
//   reset_n   in   asynchronous active-low reset
//   cas_len   in   number of valid image bytes, sampled on the play edge
//   play      in   level; its rising edge starts playback at rd_addr
//   rewind    in   one-cycle pulse; aborts playback, rd_addr back to 0
//   motor_on  in   cassette relay state
//   speed     in   0=1x 1=2x 2=3x 3=12x, selects the bit cell length
//   rd_en     out  one-cycle read strobe to cassette RAM
//   rd_addr   out  byte offset within the cassette region
//   rd_data   in   RAM data, valid two cycles after rd_en
//   cas_out   out  00 idle, 01 positive pulse, 10 negative pulse
//   busy      out  playback in progress
//   done      out  last byte sent; cleared by play or rewind
// -----------------------------------------------------------------------------
module cas_player #(
   parameter int CELL_1X  = 84000,
   parameter int CELL_2X  = 42000,
   parameter int CELL_3X  = 28000,
   parameter int CELL_12X = 7000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [15:0] cas_len,
   input  logic        play,
   input  logic        rewind,
   input  logic        motor_on,
   input  logic [1:0]  speed,
   output logic        rd_en,
   output logic [15:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic [1:0]  cas_out,
   output logic        busy,
   output logic        done
);

   // The 1x cell is the longest, so it sizes the cell counter.
   localparam int CW = $clog2(CELL_1X + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT1, S_WAIT2, S_CELL, S_END
   } state_t;

   state_t        state, state_n;
   logic          play_q, play_qq;
   logic [15:0]   len_q, len_n, addr_n, addr_inc;
   logic [CW-1:0] cnt, cnt_n, cell_len, cell_len_n;
   logic [CW-1:0] pw, half;
   logic [7:0]    shreg, shreg_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic          pend, pend_n;
   logic          rd_en_n, busy_n, done_n;
   logic [1:0]    cas_n;
   logic          play_edge, start_req, start, motor_run, cell_last;

   function automatic logic [CW-1:0] cell_of(input logic [1:0] s);
      case (s)
         2'd0:    cell_of = CW'(CELL_1X);
         2'd1:    cell_of = CW'(CELL_2X);
         2'd2:    cell_of = CW'(CELL_3X);
         default: cell_of = CW'(CELL_12X);
      endcase
   endfunction

`ifdef CAS_MOTOR_GATE_EN
   assign motor_run = motor_on;
`else
   // Motor is ignored in this build; the sink keeps the input visibly consumed.
   logic unused_motor;
   assign unused_motor = motor_on;
   assign motor_run    = 1'b1;
`endif

   assign play_edge = play_q & ~play_qq;
   assign start_req = play_edge && (cas_len != 16'd0) && (rd_addr < cas_len);
   // A start requested while the motor is off is held in pend until it turns on.
   assign start     = (start_req || pend) && motor_run;
   assign addr_inc  = rd_addr + 16'd1;
   assign cell_last = (cnt == cell_len - CW'(1));

   // Registers: FSM state, datapath and the registered outputs.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         play_q   <= 1'b0;
         play_qq  <= 1'b0;
         len_q    <= '0;
         cnt      <= '0;
         cell_len <= CW'(CELL_1X);
         shreg    <= '0;
         bit_idx  <= '0;
         pend     <= 1'b0;
         rd_en    <= 1'b0;
         rd_addr  <= '0;
         cas_out  <= 2'b00;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         play_q   <= play;
         play_qq  <= play_q;
         len_q    <= len_n;
         cnt      <= cnt_n;
         cell_len <= cell_len_n;
         shreg    <= shreg_n;
         bit_idx  <= bit_idx_n;
         pend     <= pend_n;
         rd_en    <= rd_en_n;
         rd_addr  <= addr_n;
         cas_out  <= cas_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

   // Next state of FSM and datapath. Rewind overrides everything.
   // The cell length is re-sampled from speed only when a new cell starts.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      cell_len_n = cell_len;
      shreg_n    = shreg;
      bit_idx_n  = bit_idx;
      addr_n     = rd_addr;
      len_n      = len_q;
      pend_n     = 1'b0;
      if (rewind) begin
         state_n = S_IDLE;
         cnt_n   = '0;
         addr_n  = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (play_edge) len_n = cas_len;
               if (start) state_n = S_FETCH;
               else       pend_n  = start_req || pend;
            end
            S_FETCH: state_n = S_WAIT1;
            S_WAIT1: state_n = S_WAIT2;
            S_WAIT2: begin
               state_n    = S_CELL;
               shreg_n    = rd_data;
               bit_idx_n  = 3'd7;
               cnt_n      = '0;
               cell_len_n = cell_of(speed);
            end
            S_CELL: begin
               if (motor_run) begin
                  if (!cell_last) begin
                     cnt_n = cnt + CW'(1);
                  end else begin
                     cnt_n = '0;
                     if (bit_idx != 3'd0) begin
                        bit_idx_n  = bit_idx - 3'd1;
                        shreg_n    = {shreg[6:0], 1'b0};
                        cell_len_n = cell_of(speed);
                     end else begin
                        addr_n  = addr_inc;
                        state_n = (addr_inc == len_q) ? S_END : S_FETCH;
                     end
                  end
               end
            end
            S_END:   state_n = S_IDLE;
            default: state_n = S_IDLE;
         endcase
      end
   end

   // Output values computed from next-state quantities, so the registered
   // outputs line up with the cell offset held in cnt.
   always_comb begin
      pw      = cell_len_n >> 4;
      half    = cell_len_n >> 1;
      rd_en_n = (state_n == S_FETCH);
      busy_n  = (state_n == S_FETCH) || (state_n == S_WAIT1) ||
                (state_n == S_WAIT2) || (state_n == S_CELL);
      cas_n   = 2'b00;
      if (state_n == S_CELL && motor_run) begin
         if (cnt_n < pw) begin
            cas_n = 2'b01;
         end else if (cnt_n < (pw << 1)) begin
            cas_n = 2'b10;
         end else if (shreg_n[7]) begin
            if (cnt_n >= half && cnt_n < half + pw)
               cas_n = 2'b01;
            else if (cnt_n >= half + pw && cnt_n < half + (pw << 1))
               cas_n = 2'b10;
         end
      end
      done_n = done;
      if (rewind)
         done_n = 1'b0;
      else if (state_n == S_END)
         done_n = 1'b1;
      else if (state == S_IDLE && play_edge)
         done_n = (cas_len == 16'd0);
   end

endmodule

// File: tb/tb_cas_player.sv
// -----------------------------------------------------------------------------
// tb_cas_player
// Self-checking bench for cas_player, run with short bit cells.
// A behavioural model walks bytes, bit cells and offsets with plain
// arithmetic. It predicts cas_out, rd_en and busy for every cycle of
// playback, plus rd_addr and done at the byte and end points.
// With CAS_MOTOR_GATE_EN defined, the model inserts frozen cycles while the
// motor is off. Otherwise the motor input is expected to have no effect.
// -----------------------------------------------------------------------------
module tb_cas_player;

   localparam int C1  = 200;
   localparam int C2  = 100;
   localparam int C3  = 72;
   localparam int C12 = 40;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [15:0] cas_len;
   logic        play, rewind, motor_on;
   logic [1:0]  speed;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data;
   logic [1:0]  cas_out;
   logic        busy, done;

   logic [7:0]  mem [0:255];
   logic [7:0]  rd_pipe;

   int n_cmp = 0;
   int n_bad = 0;
   int motor_left = 0;
   int trig_bit = -1;
   int trig_off = 0;
   int trig_kind = 0;
   int trig_speed = 0;
   int gap_len = 0;
   bit aborted;

   always #5 clk_sys = ~clk_sys;

   cas_player #(
      .CELL_1X (C1),
      .CELL_2X (C2),
      .CELL_3X (C3),
      .CELL_12X(C12)
   ) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .cas_len (cas_len),
      .play    (play),
      .rewind  (rewind),
      .motor_on(motor_on),
      .speed   (speed),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .cas_out (cas_out),
      .busy    (busy),
      .done    (done)
   );

   // Cassette RAM: data appears exactly two cycles after rd_en, X otherwise,
   // so a mistimed capture corrupts the pulse train.
   always @(posedge clk_sys) begin
      rd_pipe <= rd_en ? mem[rd_addr[7:0]] : 8'hxx;
      rd_data <= rd_pipe;
   end

   function automatic int cell_of(input logic [1:0] s);
      case (s)
         2'd0:    return C1;
         2'd1:    return C2;
         2'd2:    return C3;
         default: return C12;
      endcase
   endfunction

   // Expected level at offset o of a cell of length c carrying bit b.
   function automatic logic [1:0] exp_pulse(input int o, input int c, input logic b);
      int p;
      p = c / 16;
      if (o < p)     return 2'b01;
      if (o < 2 * p) return 2'b10;
      if (b && o >= c / 2 && o < c / 2 + p)         return 2'b01;
      if (b && o >= c / 2 + p && o < c / 2 + 2 * p) return 2'b10;
      return 2'b00;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: wait for mid-cycle, compare, then advance the motor gap.
   task automatic sample_cycle(input logic [1:0] e_cas, input logic e_rd, input logic e_busy,
                               input string tag);
      @(negedge clk_sys);
      checkOutput({tag, " cas_out"}, 32'(cas_out), 32'(e_cas));
      checkOutput({tag, " rd_en"},   32'(rd_en),   32'(e_rd));
      checkOutput({tag, " busy"},    32'(busy),    32'(e_busy));
      if (motor_left > 0) begin
         motor_left--;
         if (motor_left == 0) motor_on = 1'b1;
      end
   endtask

   // Start playback: one-cycle play pulse, edge registered inside the DUT.
   task automatic applyStimulus(input int len, input int spd);
      cas_len = 16'(len);
      speed   = 2'(spd);
      play    = 1'b1;
      sample_cycle(2'b00, 1'b0, 1'b0, "play seen");
      play    = 1'b0;
   endtask

   task automatic do_rewind();
      rewind = 1'b1;
      sample_cycle(2'b00, 1'b0, 1'b0, "rewind");
      checkOutput("rewind rd_addr", 32'(rd_addr), 32'd0);
      checkOutput("rewind done",    32'(done),    32'd0);
      rewind = 1'b0;
   endtask

   // Model of one byte: fetch, two wait cycles, then eight cells MSB first.
   task automatic check_byte(input int addr, output bit ab);
      int c;
      logic [7:0] d;
      d  = mem[addr[7:0]];
      ab = 1'b0;
      sample_cycle(2'b00, 1'b1, 1'b1, $sformatf("fetch a%0d", addr));
      checkOutput($sformatf("fetch a%0d rd_addr", addr), 32'(rd_addr), 32'(addr));
      sample_cycle(2'b00, 1'b0, 1'b1, "wait1");
      sample_cycle(2'b00, 1'b0, 1'b1, "wait2");
      for (int b = 7; b >= 0; b--) begin
         c = cell_of(speed);
         for (int o = 0; o < c; o++) begin
`ifdef CAS_MOTOR_GATE_EN
            while (motor_on == 1'b0)
               sample_cycle(2'b00, 1'b0, 1'b1, "gap");
`endif
            sample_cycle(exp_pulse(o, c, d[b]), 1'b0, 1'b1,
                         $sformatf("cell a%0d b%0d o%0d", addr, b, o));
            if (b == trig_bit && o == trig_off) begin
               trig_bit = -1;
               case (trig_kind)
                  0: speed = 2'(trig_speed);
                  1: begin
                     motor_on   = 1'b0;
                     motor_left = gap_len;
                  end
                  default: begin
                     ab = 1'b1;
                     return;
                  end
               endcase
            end
         end
      end
   endtask

   task automatic check_end(input int len);
      sample_cycle(2'b00, 1'b0, 1'b0, "end");
      checkOutput("end done",    32'(done),    32'd1);
      checkOutput("end rd_addr", 32'(rd_addr), 32'(len));
      sample_cycle(2'b00, 1'b0, 1'b0, "after end");
      checkOutput("done held", 32'(done), 32'd1);
   endtask

   initial begin
      reset_n  = 1'b0;
      cas_len  = 16'd0;
      play     = 1'b0;
      rewind   = 1'b0;
      motor_on = 1'b1;
      speed    = 2'd3;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

      // Reset values.
      repeat (3) @(negedge clk_sys);
      checkOutput("reset rd_en",   32'(rd_en),   32'd0);
      checkOutput("reset rd_addr", 32'(rd_addr), 32'd0);
      checkOutput("reset cas_out", 32'(cas_out), 32'd0);
      checkOutput("reset busy",    32'(busy),    32'd0);
      checkOutput("reset done",    32'(done),    32'd0);
      reset_n = 1'b1;
      sample_cycle(2'b00, 1'b0, 1'b0, "idle");

      // Two-byte image: 0xA5 then 0x00 at 12x.
      $display("[TB] two-byte image at 12x");
      mem[0] = 8'hA5;
      mem[1] = 8'h00;
      applyStimulus(2, 3);
      check_byte(0, aborted);
      check_byte(1, aborted);
      check_end(2);

      // Address already at cas_len: play must not start, but clears done.
      applyStimulus(2, 3);
      sample_cycle(2'b00, 1'b0, 1'b0, "no start");
      checkOutput("done cleared by play", 32'(done), 32'd0);
      sample_cycle(2'b00, 1'b0, 1'b0, "no start 2");

      // Empty image: done immediately, no read.
      $display("[TB] empty image");
      do_rewind();
      applyStimulus(0, 3);
      sample_cycle(2'b00, 1'b0, 1'b0, "empty");
      checkOutput("empty done", 32'(done), 32'd1);
      sample_cycle(2'b00, 1'b0, 1'b0, "empty 2");
      checkOutput("empty rd_addr", 32'(rd_addr), 32'd0);

      // Rewind in the middle of byte 5, then replay the whole image.
      $display("[TB] rewind mid byte 5");
      do_rewind();
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
      applyStimulus(8, 3);
      for (int i = 0; i < 5; i++) check_byte(i, aborted);
      trig_kind = 2;
      trig_bit  = int'($urandom_range(0, 7));
      trig_off  = int'($urandom_range(0, C12 - 1));
      check_byte(5, aborted);
      do_rewind();
      checkOutput("rewind busy", 32'(busy), 32'd0);
      sample_cycle(2'b00, 1'b0, 1'b0, "after rewind");
      applyStimulus(8, int'($urandom_range(0, 3)));
      for (int i = 0; i < 8; i++) check_byte(i, aborted);
      check_end(8);

      // Speed change 1x -> 12x in the middle of the first cell.
      $display("[TB] speed change mid cell");
      do_rewind();
      mem[0]     = 8'($urandom) | 8'h81;
      trig_kind  = 0;
      trig_bit   = 7;
      trig_off   = 50;
      trig_speed = 3;
      applyStimulus(1, 0);
      check_byte(0, aborted);
      check_end(1);

      // Motor drop for 500 cycles at offset 5 of the first cell.
      $display("[TB] motor drop mid pulse");
      do_rewind();
      mem[0]    = 8'($urandom);
      trig_kind = 1;
      trig_bit  = 7;
      trig_off  = 5;
      gap_len   = 500;
      applyStimulus(1, 0);
      check_byte(0, aborted);
      check_end(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cas_player.md
# cas_player

Cassette playback engine for the TRS-80 core. It reads a downloaded CAS image byte by byte from the cassette region of the download RAM (the 0x10000–0x1FFFF half of the download address space). It regenerates the Level II 500-baud pulse train on the machine's cassette input, so ROM CLOAD/SYSTEM routines load the tape exactly as from a real recorder. It sits between the cassette memory (upstream) and the `trs80` cassette-in path (downstream), gated by the cassette motor relay.

## Interface
Parameters:
- `CELL_1X`, default 84000: clk_sys cycles per 2 ms bit cell at 1x CPU speed (42 MHz).
- `CELL_2X`, default 42000: cycles per bit cell at 2x.
- `CELL_3X`, default 28000: cycles per bit cell at 3x.
- `CELL_12X`, default 7000: cycles per bit cell at 12x.

Ports:
- `clk_sys` in 1: 42 MHz system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cas_len` in 16: number of valid bytes in the image; sampled on the `play` rising edge.
- `play` in 1: level; rising edge starts playback from the current address.
- `rewind` in 1: one-cycle pulse; address returns to 0 and playback aborts.
- `motor_on` in 1: cassette relay state from port 0xFF.
- `speed` in 2: 0=1x, 1=2x, 2=3x, 3=12x; selects the cell length.
- `rd_en` out 1: one-cycle read strobe to cassette RAM.
- `rd_addr` out 16: byte offset within the cassette region.
- `rd_data` in 8: RAM data, valid exactly 2 cycles after `rd_en`.
- `cas_out` out 2: 2'b00 = idle/zero level, 2'b01 = positive pulse, 2'b10 = negative pulse.
- `busy` out 1: playback in progress.
- `done` out 1: set when the last byte has been sent; cleared by `play` or `rewind`.

## Operation
- States are IDLE, FETCH, WAIT1, WAIT2, CELL and END.
- IDLE to FETCH: on the `play` rising edge when `cas_len` ≠ 0 and `rd_addr` < `cas_len`. `play` with `cas_len` = 0 sets `done` immediately.
- FETCH: assert `rd_en` for 1 cycle, go to WAIT1, then WAIT2. In WAIT2, latch `rd_data` into the shift register, set the bit index to 7 and enter CELL.
- CELL:
  - Cell counter runs 0..C-1, where C = the `speed`-selected cell length and P = C/16 (integer, truncating).
  - Clock pulse: offset 0..P-1 drives 01, offset P..2P-1 drives 10.
  - Data pulse: only when the current bit is 1, offset C/2..C/2+P-1 drives 01, then C/2+P..C/2+2P-1 drives 10.
  - All other offsets drive 00.
  - Bits are sent MSB first.
- End of cell (counter = C-1):
  - If bit index ≠ 0: decrement the index, shift the register and restart the cell.
  - Else increment `rd_addr`. If the new `rd_addr` = `cas_len`, go to END; otherwise go to FETCH.
  - Inter-byte fetch time (3 cycles) is added to the next cell and is not compensated.
- END: `cas_out` = 00, `busy` = 0, `done` = 1, go to IDLE.
- `busy` = 1 in FETCH, WAIT1, WAIT2 and CELL.
- `speed` is sampled only at the start of each cell. A change mid-cell takes effect at the next cell.
- `rewind` has priority over every other event. In any state it gives: state IDLE, `rd_addr` 0, `cas_out` 00, `done` 0, and no `rd_en`.
- `play` falling mid-playback has no effect; playback stops only via END or `rewind`.
- `rd_addr` wraps from 0xFFFF to 0x0000 only if `cas_len` = 0 is misused; the `cas_len` = 0 guard prevents this.

## Timing
- Reset values: state IDLE, `rd_en` 0, `rd_addr` 0, `cas_out` 00, `busy` 0, `done` 0, cell counter 0.
- All outputs are registered.
- First `rd_en` occurs 1 cycle after the `play` rising edge is detected. `play` is registered, so the edge is seen 1 cycle after it rises.
- First `cas_out` = 01 occurs 3 cycles after `rd_en`.
- `rd_data` is sampled exactly 2 cycles after `rd_en`. There is no handshake back-pressure.
- Byte period is 8·C + 3 cycles.

## Configuration
- Macro: `CAS_MOTOR_GATE_EN`.
- Defined:
  - While `motor_on` = 0, the cell counter and FSM freeze in CELL and `cas_out` is forced to 00.
  - FETCH is not entered while the motor is off.
  - On `motor_on` returning to 1, the cell resumes from the frozen offset.
- Undefined: `motor_on` is ignored and playback runs free once started.

## Test plan
- Reset with `cas_len`=2, RAM[0]=0xA5, RAM[1]=0x00, `speed`=3 (C=7000, P=437), pulse `play`:
  - Required: `rd_en` at addr 0, then addr 1.
  - Cell 0: `cas_out` = 01 for cycles 0–436 and 10 for 437–873, plus a data pulse at offset 3500.
  - Byte 0x00 produces clock pulses only.
  - `done` = 1 after 16 cells; `busy` falls in the same cycle.
- `play` with `cas_len`=0: `done`=1 next cycle, no `rd_en`, `busy` stays 0.
- `rewind` pulsed mid-cell of byte 5: next cycle `rd_addr`=0, `cas_out`=00, `busy`=0, `done`=0. A following `play` refetches addr 0.
- `speed` changed 0→3 at cell offset 1000: the current cell completes at 84000 cycles and the next cell lasts 7000.
- With `CAS_MOTOR_GATE_EN` defined, drop `motor_on` for 5000 cycles at offset 200:
  - `cas_out`=00 throughout the gap.
  - On resume, the 01 pulse continues for the remaining 237 cycles of P.
  - Total byte period grows by exactly 5000.
- Without the macro, repeat the previous scenario: `motor_on` is ignored and the timing is identical to the ungated run.
